// File: rtl/sc_bus_reader.sv
// sc_bus_reader: 2**DEPTH_LOG2-deep registered bus buffer between a valid/ready producer and consumer.
//   SC_BUS_READER_CLOCK_50       clock; all state changes on its rising edge
//   SC_BUS_READER_RESET_InLow    asynchronous active-low reset
//   SC_BUS_READER_DataBUS_In     producer word
//   SC_BUS_READER_Valid_In       producer word valid
//   SC_BUS_READER_Ready_Out      buffer not full
//   SC_BUS_READER_DataBUS_Out    head word, zero when empty
//   SC_BUS_READER_Valid_Out      buffer not empty
//   SC_BUS_READER_Ready_In       consumer takes head word
//   SC_BUS_READER_Count_Out      stored words, 0..DEPTH
//   SC_BUS_READER_Overflow_Out   sticky: word offered while full
module sc_bus_reader #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DEPTH_LOG2    = 2
) (
  input  logic                     SC_BUS_READER_CLOCK_50,
  input  logic                     SC_BUS_READER_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0] SC_BUS_READER_DataBUS_In,
  input  logic                     SC_BUS_READER_Valid_In,
  output logic                     SC_BUS_READER_Ready_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_BUS_READER_DataBUS_Out,
  output logic                     SC_BUS_READER_Valid_Out,
  input  logic                     SC_BUS_READER_Ready_In,
  output logic [DEPTH_LOG2:0]      SC_BUS_READER_Count_Out,
  output logic                     SC_BUS_READER_Overflow_Out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PONE = 1;
  logic [DATAWIDTH_BUS-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic ovf_q, ovf_d, wr, rd;
  // Reset gates Ready_Out so it reads 0 while held, yet is 1 before the first edge after release.
  assign SC_BUS_READER_Ready_Out    = SC_BUS_READER_RESET_InLow && (count_q != FULL);
  assign SC_BUS_READER_Valid_Out    = count_q != '0;
  assign SC_BUS_READER_DataBUS_Out  = SC_BUS_READER_Valid_Out ? mem_q[rd_ptr_q] : '0;
  assign SC_BUS_READER_Count_Out    = count_q;
  assign SC_BUS_READER_Overflow_Out = ovf_q;
  always_comb begin
    wr       = SC_BUS_READER_Valid_In && SC_BUS_READER_Ready_Out;
    rd       = SC_BUS_READER_Valid_Out && SC_BUS_READER_Ready_In;
    wr_ptr_d = wr ? wr_ptr_q + PONE : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PONE : rd_ptr_q;
    count_d  = (wr && !rd) ? count_q + CONE : (rd && !wr) ? count_q - CONE : count_q;
    ovf_d    = ovf_q || (SC_BUS_READER_Valid_In && !SC_BUS_READER_Ready_Out);
  end
  always_ff @(posedge SC_BUS_READER_CLOCK_50 or negedge SC_BUS_READER_RESET_InLow) begin
    if (!SC_BUS_READER_RESET_InLow) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (wr) mem_q[wr_ptr_q] <= SC_BUS_READER_DataBUS_In;
    end
  end
endmodule

// File: tb/tb_sc_bus_reader.sv
// tb_sc_bus_reader: directed table and sequence checks for sc_bus_reader.
module tb_sc_bus_reader;
  logic clk = 0, rst_n = 0, vi = 0, ri = 0, rdy, vld, ovf;
  logic [31:0] din = '0, dout;
  logic [2:0] cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sc_bus_reader dut (
    .SC_BUS_READER_CLOCK_50(clk), .SC_BUS_READER_RESET_InLow(rst_n),
    .SC_BUS_READER_DataBUS_In(din), .SC_BUS_READER_Valid_In(vi),
    .SC_BUS_READER_Ready_Out(rdy), .SC_BUS_READER_DataBUS_Out(dout),
    .SC_BUS_READER_Valid_Out(vld), .SC_BUS_READER_Ready_In(ri),
    .SC_BUS_READER_Count_Out(cnt), .SC_BUS_READER_Overflow_Out(ovf));
  typedef struct {
    logic vi; logic ri; logic [31:0] d;
    logic rdy; logic vld; logic [31:0] q; logic [2:0] cnt; logic ovf;
  } vec_t;
  vec_t tbl[22];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic e_rdy, e_vld, input logic [31:0] e_q,
                         input logic [2:0] e_cnt, input logic e_ovf);
    chk({tag, " ready"}, 32'(rdy), 32'(e_rdy));
    chk({tag, " valid"}, 32'(vld), 32'(e_vld));
    chk({tag, " data"}, dout, e_q);
    chk({tag, " count"}, 32'(cnt), 32'(e_cnt));
    chk({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
  endtask
  task automatic step(input logic v, input logic r, input logic [31:0] d);
    @(negedge clk);
    vi = v; ri = r; din = d;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic v, logic r, logic [31:0] d, logic e_rdy, logic e_vld,
                              logic [31:0] e_q, logic [2:0] e_cnt, logic e_ovf);
    vec_t t;
    t.vi = v; t.ri = r; t.d = d; t.rdy = e_rdy; t.vld = e_vld; t.q = e_q; t.cnt = e_cnt; t.ovf = e_ovf;
    return t;
  endfunction
  initial begin
    logic [31:0] s [11];
    logic [31:0] q [$];
    logic movf;
    tbl[0]  = mk(1, 0, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, 0);
    tbl[1]  = mk(0, 1, 32'h0,        1, 0, 32'h0,        0, 0);
    tbl[2]  = mk(1, 0, 32'h11111111, 1, 1, 32'h11111111, 1, 0);
    tbl[3]  = mk(1, 0, 32'h22222222, 1, 1, 32'h11111111, 2, 0);
    tbl[4]  = mk(1, 0, 32'h33333333, 1, 1, 32'h11111111, 3, 0);
    tbl[5]  = mk(1, 0, 32'h44444444, 0, 1, 32'h11111111, 4, 0);
    tbl[6]  = mk(1, 0, 32'h55555555, 0, 1, 32'h11111111, 4, 1);
    tbl[7]  = mk(0, 1, 32'h0,        1, 1, 32'h22222222, 3, 1);
    tbl[8]  = mk(0, 1, 32'h0,        1, 1, 32'h33333333, 2, 1);
    tbl[9]  = mk(0, 1, 32'h0,        1, 1, 32'h44444444, 1, 1);
    tbl[10] = mk(0, 1, 32'h0,        1, 0, 32'h0,        0, 1);
    tbl[11] = mk(1, 0, 32'h66666666, 1, 1, 32'h66666666, 1, 1);
    tbl[12] = mk(1, 0, 32'h77777777, 1, 1, 32'h66666666, 2, 1);
    tbl[13] = mk(1, 0, 32'h88888888, 1, 1, 32'h66666666, 3, 1);
    tbl[14] = mk(1, 0, 32'h99999999, 0, 1, 32'h66666666, 4, 1);
    tbl[15] = mk(1, 1, 32'hAAAAAAAA, 1, 1, 32'h77777777, 3, 1);
    tbl[16] = mk(1, 0, 32'hBBBBBBBB, 0, 1, 32'h77777777, 4, 1);
    tbl[17] = mk(0, 0, 32'h0,        0, 1, 32'h77777777, 4, 1);
    tbl[18] = mk(0, 1, 32'h0,        1, 1, 32'h88888888, 3, 1);
    tbl[19] = mk(0, 1, 32'h0,        1, 1, 32'h99999999, 2, 1);
    tbl[20] = mk(0, 1, 32'h0,        1, 1, 32'hBBBBBBBB, 1, 1);
    tbl[21] = mk(0, 1, 32'h0,        1, 0, 32'h0,        0, 1);
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk_all("release", 1, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].vi, tbl[i].ri, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].vld, tbl[i].q, tbl[i].cnt, tbl[i].ovf);
    end
    step(1, 0, 32'hC0C0C0C0);
    chk_all("stream pre", 1, 1, 32'hC0C0C0C0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      s[i] = 32'h5000_0000 + 32'(i * 32'h0101);
      step(1, 1, s[i]);
      chk($sformatf("stream%0d count", i), 32'(cnt), 32'd1);
      chk($sformatf("stream%0d data", i), dout, s[i]);
    end
    step(0, 1, 0);
    chk_all("stream drain", 1, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk_all("mid reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) step(1, 0, 32'hE000_0000 + 32'(i));
    step(1, 0, 32'hE5E5E5E5);
    step(0, 1, 0);
    chk_all("pre async", 1, 1, 32'hE0000001, 3, 1);
    #3;
    rst_n = 0;
    #1;
    chk_all("async", 0, 0, 0, 0, 0);
    step(1, 1, 32'hF00DF00D);
    chk_all("held reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    vi = 0; ri = 0;
    #1;
    chk_all("after async", 1, 0, 0, 0, 0);
    movf = 0;
    for (int i = 0; i < 14; i++) begin
      logic r, mr, mv;
      r = (i % 2 == 0);
      mr = q.size() < 4;
      mv = q.size() > 0;
      if (!mr) movf = 1;
      if (r && mv) void'(q.pop_front());
      if (mr) q.push_back(32'hB000_0000 + 32'(i));
      step(1, r, 32'hB000_0000 + 32'(i));
      chk($sformatf("bp%0d count", i), 32'(cnt), 32'(q.size()));
      chk($sformatf("bp%0d data", i), dout, q.size() > 0 ? q[0] : 32'h0);
      chk($sformatf("bp%0d ovf", i), 32'(ovf), 32'(movf));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sc_bus_reader.md
SC_BUS_READER -- requirements
Module: sc_bus_reader

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 32, width of bus word.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, log2 of buffer depth (DEPTH = 2**DEPTH_LOG2 = 4).
REQ-003 SHALL have port SC_BUS_READER_CLOCK_50  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port SC_BUS_READER_RESET_InLow  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SC_BUS_READER_DataBUS_In  input  DATAWIDTH_BUS  word driven onto bus by producer.
REQ-006 SHALL have port SC_BUS_READER_Valid_In  input  1  producer asserts word valid.
REQ-007 SHALL have port SC_BUS_READER_Ready_Out  output  1  buffer can accept word (not full).
REQ-008 SHALL have port SC_BUS_READER_DataBUS_Out  output  DATAWIDTH_BUS  head word to datapath consumer.
REQ-009 SHALL have port SC_BUS_READER_Valid_Out  output  1  head word valid (not empty).
REQ-010 SHALL have port SC_BUS_READER_Ready_In  input  1  consumer accepts head word.
REQ-011 SHALL have port SC_BUS_READER_Count_Out  output  DEPTH_LOG2+1  words currently stored, 0..DEPTH.
REQ-012 SHALL have port SC_BUS_READER_Overflow_Out  output  1  sticky: producer offered word while full.

Function
REQ-013 SHALL perform a write on an edge where Valid_In=1 and Ready_Out=1: store DataBUS_In at wr_ptr, wr_ptr+1.
REQ-014 SHALL perform a read on an edge where Valid_Out=1 and Ready_In=1: rd_ptr+1, head word removed.
REQ-015 SHALL wrap wr_ptr and rd_ptr modulo DEPTH (DEPTH_LOG2-bit pointers, wrap 3->0 at default).
REQ-016 SHALL drive Ready_Out = (Count_Out != DEPTH) and Valid_Out = (Count_Out != 0), both decoded from registered state only (no combinational path from Valid_In/Ready_In).
REQ-017 SHALL update Count_Out: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-018 SHALL allow simultaneous write and read when 0 < Count_Out < DEPTH; data order preserved, count unchanged.
REQ-019 SHALL when empty accept a write only; no pass-through; word appears on DataBUS_Out with Valid_Out=1 one cycle after the write edge (latency 1).
REQ-020 SHALL when full ignore Valid_In (Ready_Out=0); a read on that edge frees a slot usable from the next cycle only.
REQ-021 SHALL drive DataBUS_Out = storage[rd_ptr] when Valid_Out=1 and all zeros when Valid_Out=0.
REQ-022 SHALL set Overflow_Out on an edge where Valid_In=1 and Ready_Out=0; remains 1 until reset; dropped word not stored.
REQ-023 SHALL never change storage, pointers or count when neither write nor read occurs.
REQ-024 SHALL hold DataBUS_Out stable while Valid_Out=1 and Ready_In=0.

Reset
REQ-025 SHALL on RESET_InLow=0 asynchronously clear wr_ptr, rd_ptr, Count_Out, Overflow_Out, and all storage to 0.
REQ-026 SHALL during reset drive Ready_Out=0, Valid_Out=0, DataBUS_Out=0, Count_Out=0, Overflow_Out=0.
REQ-027 SHALL after reset release assert Ready_Out=1 from the first edge; first write accepted on the first edge with Valid_In=1.
REQ-028 SHALL on reset asserted mid-transfer discard all stored words; no partial write completes on that edge.

Verification
REQ-029 SHALL cover fill/drain: write 0x11111111..0x44444444 with Ready_In=0 -> Count_Out=4, Ready_Out=0; then Ready_In=1 -> outputs 0x11111111,0x22222222,0x33333333,0x44444444 in order, Count_Out ends 0, Valid_Out=0, DataBUS_Out=0.
REQ-030 SHALL cover latency: single write 0xDEADBEEF into empty buffer -> Valid_Out=1, DataBUS_Out=0xDEADBEEF exactly one cycle later.
REQ-031 SHALL cover overflow: 5th word 0x55555555 offered while full -> Overflow_Out=1 next cycle, stays 1; 0x55555555 never appears on DataBUS_Out.
REQ-032 SHALL cover streaming: Valid_In=1, Ready_In=1 continuously for 10 words starting from Count_Out=1 -> Count_Out stays 1, pointers wrap twice, output order equals input order.
REQ-033 SHALL cover async reset: assert RESET_InLow=0 between edges with Count_Out=3, Overflow_Out=1 -> all outputs zero immediately, before next clock edge.
REQ-034 SHALL cover backpressure: Ready_In toggled 1/0 each cycle with Valid_In=1 -> no loss, no duplication, DataBUS_Out stable during Ready_In=0 cycles.
